// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and timeout defaults.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_START = 2'd1,
    ST_MEM_WAIT  = 2'd2,
    ST_MEM_DONE  = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned TMO_W       = 8;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/branch/memory handshake bundle between the pipeline and its stall controller.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_done;
  logic             sram_start;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             freeze_id_exe;
  logic             freeze_exe_mem;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard, branch_taken, mem_req, sram_done,
    input  sram_start, freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
    input  flush_if_id, flush_id_exe, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_req, sram_done,
    output sram_start, freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
    output flush_if_id, flush_id_exe, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: services RAW hazards and taken branches in RUN,
// and freezes the whole pipe around each SRAM access with a bounded wait.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic start, fpc, fif, fide, fem, flif, flide;
  logic freeze_pc_o, flush_if_id_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    start   = 1'b0;
    fpc     = 1'b0;
    fif     = 1'b0;
    fide    = 1'b0;
    fem     = 1'b0;
    flif    = 1'b0;
    flide   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // memory access wins; a pending branch/hazard is held by the frozen stages
        if (bus.mem_req) begin
          state_d = ST_MEM_START;
        end else if (bus.branch_taken) begin
          flif  = 1'b1;
          flide = 1'b1;
        end else if (bus.hazard) begin
          fpc   = 1'b1;
          fif   = 1'b1;
          flide = 1'b1;
        end
      end
      ST_MEM_START: begin
        start   = 1'b1;
        {fpc, fif, fide, fem} = 4'b1111;
        tmo_d   = '0;
        state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        {fpc, fif, fide, fem} = 4'b1111;
        if (bus.sram_done) begin
          state_d = ST_MEM_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_MEM_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_MEM_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // outputs forced low while reset is held, since RUN decodes the raw inputs
  assign freeze_pc_o        = fpc  & ~rst;
  assign flush_if_id_o      = flif & ~rst;
  assign bus.sram_start     = start & ~rst;
  assign bus.freeze_pc      = freeze_pc_o;
  assign bus.freeze_if_id   = fif  & ~rst;
  assign bus.freeze_id_exe  = fide & ~rst;
  assign bus.freeze_exe_mem = fem  & ~rst;
  assign bus.flush_if_id    = flush_if_id_o;
  assign bus.flush_id_exe   = flide & ~rst;
  assign bus.mem_err        = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (freeze_pc_o),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (flush_if_id_o),
    .cnt_o (bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, corner sequences, random vs. reference model.
module tb_pipe_stall_ctrl;
  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus();

  pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: which part of an access we are in, and how long we have waited
  bit in_access;
  int acc_cycle;
  bit done_seen;
  int waited;
  bit m_err;
  int m_scnt, m_fcnt;

  typedef struct {
    logic h, b, m, d;
    logic [6:0] exp;
  } vec_t;

  function automatic logic [15:0] dut_vec();
    return {bus.sram_start, bus.freeze_pc, bus.freeze_if_id, bus.freeze_id_exe,
            bus.freeze_exe_mem, bus.flush_if_id, bus.flush_id_exe, bus.mem_err,
            bus.stall_cnt, bus.flush_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    in_access = 0;
    acc_cycle = 0;
    done_seen = 0;
    waited    = 0;
    m_err     = 0;
    m_scnt    = 0;
    m_fcnt    = 0;
  endtask

  // {sram_start, fpc, fif, fide, fem, flush_if_id, flush_id_exe}
  function automatic logic [6:0] model_out(input logic h, b, m);
    if (!in_access) begin
      if (m)      return 7'b0000000;
      else if (b) return 7'b0000011;
      else if (h) return 7'b0110001;
      else        return 7'b0000000;
    end
    if (done_seen)      return 7'b0000000;
    if (acc_cycle == 0) return 7'b1111100;
    return 7'b0111100;
  endfunction

  task automatic model_advance(input logic h, b, m, d, input logic [6:0] o);
    if (o[5]) m_scnt = (m_scnt >= CMAX) ? CMAX : m_scnt + 1;
    if (o[1]) m_fcnt = (m_fcnt >= CMAX) ? CMAX : m_fcnt + 1;
    if (!in_access) begin
      if (m) begin
        in_access = 1;
        acc_cycle = 0;
        done_seen = 0;
        waited    = 0;
      end
    end else if (done_seen) begin
      in_access = 0;
    end else if (acc_cycle == 0) begin
      acc_cycle = 1;
    end else begin
      waited++;
      if (d) done_seen = 1;
      else if (waited == TO) begin
        m_err     = 1;
        done_seen = 1;
      end
    end
  endtask

  task automatic step(input logic h, b, m, d, input string tag);
    logic [6:0] o;
    @(negedge clk);
    bus.hazard = h; bus.branch_taken = b; bus.mem_req = m; bus.sram_done = d;
    #1;
    o = model_out(h, b, m);
    check(tag, 32'(dut_vec()), 32'({o, m_err, m_scnt[CW-1:0], m_fcnt[CW-1:0]}));
    model_advance(h, b, m, d, o);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.hazard = 0; bus.branch_taken = 0; bus.mem_req = 0; bus.sram_done = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  vec_t tbl [8];
  int starts, frz, fl;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0110001};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b0000011};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 7'b0000011};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0000000};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b0000000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b0110001};

    // reset with active inputs: everything low
    rst = 1'b1;
    bus.hazard = 1; bus.branch_taken = 1; bus.mem_req = 1; bus.sram_done = 1;
    #12;
    check("reset_vals", 32'(dut_vec()), 32'd0);
    do_reset();

    // combinational RUN decode; inputs cleared before each rising edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.hazard = tbl[i].h; bus.branch_taken = tbl[i].b;
      bus.mem_req = tbl[i].m; bus.sram_done = tbl[i].d;
      #1;
      check($sformatf("tbl%0d", i), 32'(dut_vec()), 32'({tbl[i].exp, 1'b0, 8'd0}));
      #1;
      bus.hazard = 0; bus.branch_taken = 0; bus.mem_req = 0; bus.sram_done = 0;
    end

    // single-cycle hazard
    do_reset();
    step(1, 0, 0, 0, "haz");
    check("haz_fpc", 32'(bus.freeze_pc), 32'd1);
    check("haz_flide", 32'(bus.flush_id_exe), 32'd1);
    check("haz_fide", 32'(bus.freeze_id_exe), 32'd0);
    step(0, 0, 0, 0, "haz_after");
    check("haz_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // branch overrides hazard
    do_reset();
    step(1, 1, 0, 0, "br_haz");
    check("brh_fpc", 32'(bus.freeze_pc), 32'd0);
    check("brh_flif", 32'(bus.flush_if_id), 32'd1);
    step(0, 0, 0, 0, "br_after");
    check("brh_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // memory access with sram_done on the 3rd wait cycle
    do_reset();
    starts = 0; frz = 0;
    step(0, 0, 1, 0, "mem_c0");
    for (int c = 1; c <= 5; c++) begin
      step(0, 0, 0, (c == 4), $sformatf("mem_c%0d", c));
      starts += int'(bus.sram_start);
      frz    += int'(bus.freeze_pc);
    end
    check("mem_done_frz", 32'(bus.freeze_exe_mem), 32'd0);
    check("mem_starts", 32'(starts), 32'd1);
    check("mem_frz_cycles", 32'(frz), 32'd4);
    step(1, 0, 0, 0, "mem_c6");
    check("mem_back_run", 32'(bus.freeze_pc), 32'd1);

    // timeout with a branch held across the access
    do_reset();
    step(0, 1, 1, 0, "to_c0");
    check("to_c0_noflush", 32'(bus.flush_if_id), 32'd0);
    fl = 0;
    for (int c = 1; c <= 5; c++) begin
      step(0, 1, 0, 0, $sformatf("to_c%0d", c));
      fl += int'(bus.flush_if_id) + int'(bus.flush_id_exe);
    end
    check("to_wait_noflush", 32'(fl), 32'd0);
    step(0, 1, 0, 0, "to_done");
    check("to_err", 32'(bus.mem_err), 32'd1);
    check("to_done_frz", 32'(bus.freeze_pc), 32'd0);
    step(0, 1, 0, 0, "to_run");
    check("to_run_flush", 32'(bus.flush_if_id), 32'd1);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, "to_idle");
    check("to_err_sticky", 32'(bus.mem_err), 32'd1);

    // asynchronous reset in MEM_WAIT, then a stray sram_done
    step(0, 0, 1, 0, "ar_c0");
    step(0, 0, 0, 0, "ar_c1");
    step(0, 0, 0, 0, "ar_c2");
    step(1, 1, 0, 0, "ar_c3");
    #1 rst = 1'b1;
    #1;
    check("ar_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    bus.hazard = 0; bus.branch_taken = 0; bus.mem_req = 0; bus.sram_done = 1;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, "ar_done_ign");
    step(0, 0, 0, 1, "ar_done_ign2");
    check("ar_no_start", 32'(bus.sram_start), 32'd0);
    step(1, 0, 0, 0, "ar_run");
    check("ar_run_fpc", 32'(bus.freeze_pc), 32'd1);

    // random traffic against the model (counters saturate quickly at CW=4)
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 6) == 0), logic'($urandom_range(0, 3) == 0),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of MEM_WAIT cycles without sram_done before the wait is abandoned (range 1..255).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of each performance counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hazard  input  1  RAW hazard detected in ID.
REQ-006 branch_taken  input  1  taken branch resolved in EXE.
REQ-007 mem_req  input  1  load or store present in MEM stage.
REQ-008 sram_done  input  1  SRAM access complete; may assert any cycle after sram_start.
REQ-009 sram_start  output  1  one-cycle pulse that launches an SRAM access.
REQ-010 freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem  output  1 each  hold the PC and stage registers.
REQ-011 flush_if_id, flush_id_exe  output  1 each  synchronous bubble insertion into stage registers.
REQ-012 mem_err  output  1  sticky: an SRAM access timed out.
REQ-013 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-014 FSM states SHALL be RUN, MEM_START, MEM_WAIT and MEM_DONE; reset state RUN.
REQ-015 RUN with mem_req=1 SHALL transition to MEM_START; otherwise it SHALL stay in RUN.
REQ-016 MEM_START SHALL assert sram_start for exactly one cycle, assert all four freezes, and transition to MEM_WAIT.
REQ-017 MEM_WAIT SHALL assert all four freezes; sram_done=1 SHALL transition to MEM_DONE.
REQ-018 MEM_DONE SHALL deassert all freezes for one cycle so the access retires; the next state SHALL be RUN.
REQ-019 The MEM_WAIT timeout counter SHALL clear on entry to MEM_WAIT.
REQ-020 When the counter reaches TIMEOUT with sram_done=0, the block SHALL set mem_err and transition to MEM_DONE.
REQ-021 In RUN, freezes and flushes SHALL be combinational from the inputs (zero-cycle latency).
REQ-022 In RUN, branch_taken=1 SHALL assert flush_if_id and flush_id_exe and no freezes; branch_taken overrides hazard.
REQ-023 In RUN with hazard=1 and branch_taken=0, the block SHALL assert freeze_pc, freeze_if_id and flush_id_exe, with freeze_id_exe=0 and freeze_exe_mem=0.
REQ-024 mem_req SHALL take priority over branch_taken and hazard in RUN: no flushes are issued in the cycle RUN leaves.
REQ-025 A branch or hazard that is still present SHALL be serviced after returning to RUN, because it is held by the frozen stages.
REQ-026 In any state other than RUN, hazard and branch_taken SHALL be ignored, and flush_if_id and flush_id_exe SHALL be 0.
REQ-027 sram_done while in RUN or MEM_START SHALL be ignored.
REQ-028 stall_cnt SHALL increment on every cycle in which freeze_pc=1, saturating at all-ones.
REQ-029 flush_cnt SHALL increment on every cycle in which flush_if_id=1, saturating at all-ones.
REQ-030 mem_err SHALL clear only on reset.

Reset
REQ-031 On rst, the state SHALL be RUN, and sram_start, mem_err, the timeout counter, stall_cnt and flush_cnt SHALL be 0.
REQ-032 rst mid-access SHALL abandon the access immediately with no sram_start re-issue; the first cycle after release SHALL be RUN.
REQ-033 With rst=1, all freeze and flush outputs SHALL be 0.

Structure
REQ-034 The state encoding (2-bit enum) and the TIMEOUT default SHALL reside in the shared pipeline package.
REQ-035 One sub-module, sat_counter (CNT_W-bit saturating incrementer with enable), SHALL be instantiated twice.

Verification
REQ-036 hazard=1 for 1 cycle in RUN: freeze_pc=1, freeze_if_id=1 and flush_id_exe=1 that cycle; stall_cnt 0->1.
REQ-037 branch_taken=1 and hazard=1 together: flush_if_id=1, flush_id_exe=1, freeze_pc=0; flush_cnt=1.
REQ-038 mem_req=1, sram_done at the 3rd cycle of MEM_WAIT: sram_start pulses once; freezes high for 4 cycles; MEM_DONE has freezes 0; back in RUN on the 6th cycle.
REQ-039 TIMEOUT=4 and sram_done never asserted: after 4 MEM_WAIT cycles, mem_err=1 and the state goes MEM_DONE->RUN; mem_err stays 1 until rst.
REQ-040 branch_taken=1 held during MEM_WAIT: no flushes while waiting; flush_if_id=1 in the first RUN cycle after MEM_DONE.
REQ-041 rst asserted in MEM_WAIT: outputs return to 0 asynchronously and the counters clear; a later sram_done is ignored.
